// File: rtl/core_bus_arbiter_pkg.sv
// Shared bus types for the core's memory-side interfaces, plus the
// arbiter-local FSM state and owner encodings.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [31:0] iword_t;
  typedef logic [7:0]  strobe_t;

  // Transfer size per beat, encoded as log2(bytes).
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  // Burst length, encoded as (beats - 1).
  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN4  = 4'd3,
    MLEN8  = 4'd7,
    MLEN16 = 4'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic   addr_ok;
    logic   data_ok;
    iword_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Arbiter FSM state and the client that owns the current transaction.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } arb_owner_t;

  // Select the 32-bit instruction word out of a 64-bit memory beat using
  // bit 2 of the fetch address.
  function automatic iword_t inst_word(input addr_t addr, input word_t beat);
    return addr[2] ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/core_bus_arbiter_cbus_req_pack.sv
// Combinational converter from an ibus or dbus request to a single-beat
// cbus request. The arbiter registers the result at grant time.
module cbus_req_pack
  import common::*;
(
  input  ibus_req_t ireq_i,
  input  dbus_req_t dreq_i,
  input  logic      sel_data_i,
  output cbus_req_t creq_o
);

  // Build the cbus request for whichever client is selected.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path
    // leaves a field unassigned and no latch is inferred.
    creq_o       = '0;
    creq_o.valid = 1'b1;
    creq_o.len   = MLEN1;
    creq_o.burst = AXI_BURST_FIXED;
    if (sel_data_i) begin
      creq_o.is_write = |dreq_i.strobe;
      creq_o.size     = dreq_i.size;
      creq_o.addr     = dreq_i.addr;
      creq_o.strobe   = dreq_i.strobe;
      creq_o.data     = dreq_i.data;
    end else begin
      creq_o.is_write = 1'b0;
      creq_o.size     = MSIZE4;
      creq_o.addr     = ireq_i.addr;
      creq_o.strobe   = '0;
      creq_o.data     = '0;
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Merges the instruction and data buses onto the single cbus port. One
// single-beat transaction is in flight at a time; DATA wins ties. The cbus
// request is fully registered, and each response is returned to its owner
// as a one-cycle addr_ok/data_ok pulse.
module core_bus_arbiter
  import common::*;
(
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  cbus_req_t  req_q,   req_d;
  word_t      rdata_q, rdata_d;

  cbus_req_t  grant_req;
  logic       beat_done;

  // DATA has priority, so the converter follows dreq.valid directly.
  cbus_req_pack u_pack (
    .ireq_i     (ireq),
    .dreq_i     (dreq),
    .sel_data_i (dreq.valid),
    .creq_o     (grant_req)
  );

  assign beat_done = cresp.ready && cresp.last;

  // State register: FSM state, owner, latched request and response data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples its pre-edge value regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      owner_q <= INST;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: grant in IDLE, wait for the beat in REQ, return to IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (dreq.valid || ireq.valid) begin
          state_d = REQ;
          owner_d = dreq.valid ? DATA : INST;
          req_d   = grant_req;
        end
      end
      REQ: begin
        // ready without last is impossible for a one-beat transfer and is
        // simply ignored, keeping the request on the bus.
        if (beat_done) begin
          state_d = RESP;
          req_d   = '0;
          if (owner_q == INST) begin
            rdata_d = {32'h0, inst_word(req_q.addr, cresp.data)};
          end else begin
            rdata_d = cresp.data;
          end
        end
      end
      RESP: begin
        // No grant here: a client still holding valid from the request just
        // served must not be granted a second time.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  // Output logic: registered cbus request, one-cycle response pulse to owner.
  always_comb begin
    creq  = req_q;
    iresp = '0;
    dresp = '0;
    if (state_q == RESP) begin
      if (owner_q == DATA) begin
        dresp.addr_ok = 1'b1;
        dresp.data_ok = 1'b1;
        dresp.data    = rdata_q;
      end else begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = rdata_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed stimulus pushes expected cbus
// requests and client responses into queues; a monitor pops and compares
// whenever the DUT raises creq.valid or a data_ok pulse.
module tb_core_bus_arbiter;
  import common::*;

  logic       clk = 1'b0;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  core_bus_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .creq  (creq),
    .cresp (cresp)
  );

  typedef struct {
    bit          is_data;
    logic [63:0] data;
  } exp_resp_t;

  cbus_req_t   exp_req_q[$];
  exp_resp_t   exp_resp_q[$];
  logic [63:0] mem_q[$];

  int checks    = 0;
  int errors    = 0;
  int mem_lat   = 1;
  int txn_count = 0;
  bit fire_prev = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cbus_req_t mk_req(input logic w, input msize_t sz, input logic [63:0] a,
                                       input logic [7:0] st, input logic [63:0] d);
    cbus_req_t r;
    r          = '0;
    r.valid    = 1'b1;
    r.is_write = w;
    r.size     = sz;
    r.addr     = a;
    r.strobe   = st;
    r.data     = d;
    r.len      = MLEN1;
    r.burst    = AXI_BURST_FIXED;
    return r;
  endfunction

  function automatic exp_resp_t mk_resp(input bit is_data, input logic [63:0] d);
    exp_resp_t r;
    r.is_data = is_data;
    r.data    = d;
    return r;
  endfunction

  // Memory model: answers ready=last=1 after mem_lat cycles of creq.valid.
  initial begin
    int cnt;
    cnt   = 0;
    cresp = '0;
    forever begin
      @(negedge clk);
      if (reset || !creq.valid || cresp.ready) begin
        cnt   = 0;
        cresp = '0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          cresp.ready = 1'b1;
          cresp.last  = 1'b1;
          cresp.data  = (mem_q.size() != 0) ? mem_q.pop_front() : 64'h0;
        end
      end
    end
  end

  // Edge sampler: records completed beats as the DUT sees them.
  initial begin
    forever begin
      @(posedge clk);
      fire_prev = creq.valid && cresp.ready && cresp.last && !reset;
      if (fire_prev) txn_count++;
    end
  end

  // Monitor: compares new cbus requests and client responses to the scoreboard.
  initial begin
    bit        prev_valid;
    cbus_req_t er;
    exp_resp_t ep;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (creq.valid && !prev_valid) begin
        if (exp_req_q.size() == 0) begin
          check("creq_unexpected", 1, 0);
        end else begin
          er = exp_req_q.pop_front();
          check("creq_fields", creq, er);
        end
      end
      prev_valid = creq.valid;

      if (iresp.data_ok || dresp.data_ok) begin
        if (exp_resp_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          ep = exp_resp_q.pop_front();
          check("resp_owner", {dresp.data_ok, iresp.data_ok}, ep.is_data ? 2'b10 : 2'b01);
          if (ep.is_data) begin
            check("dresp_data", dresp.data, ep.data);
            check("dresp_addr_ok", dresp.addr_ok, 1);
            check("iresp_idle_zero", iresp, 0);
          end else begin
            check("iresp_data", iresp.data, ep.data);
            check("iresp_addr_ok", iresp.addr_ok, 1);
            check("dresp_idle_zero", dresp, 0);
          end
        end
      end

      if (fire_prev) begin
        check("data_ok_after_beat", iresp.data_ok | dresp.data_ok, 1);
        check("creq_drop_after_beat", creq.valid, 0);
      end
    end
  end

  task automatic wait_dok(input bit is_data, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_data ? dresp.data_ok : iresp.data_ok) && n < max_cyc);
    if (!(is_data ? dresp.data_ok : iresp.data_ok))
      check(is_data ? "timeout_dresp" : "timeout_iresp", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;

    // Reset with both clients requesting; DATA must win the first grant.
    mem_lat     = 2;
    ireq.valid  = 1'b1;
    ireq.addr   = 64'h8000_0000;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_2000;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_2000, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b1, 64'hAAAA_BBBB_CCCC_DDDD));
    mem_q.push_back(64'hAAAA_BBBB_CCCC_DDDD);
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_0000, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b0, 64'h7777_8888));
    mem_q.push_back(64'h5555_6666_7777_8888);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_creq", creq, 0);
      check("reset_iresp", iresp, 0);
      check("reset_dresp", dresp, 0);
    end
    reset = 1'b0;
    @(negedge clk);
    check("first_grant_valid", creq.valid, 1);
    check("first_grant_owner", dut.owner_q, DATA);
    wait_dok(1'b1, 20);
    dreq.valid = 1'b0;
    wait_dok(1'b0, 20);
    ireq.valid = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait instruction fetch from the upper word.
    mem_lat = 1;
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_0004, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b0, 64'h1111_2222));
    mem_q.push_back(64'h1111_2222_3333_4444);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0004;
    @(negedge clk);
    check("zw_creq_valid", creq.valid, 1);
    @(negedge clk);
    check("zw_data_ok", iresp.data_ok, 1);
    check("zw_data", iresp.data, 32'h1111_2222);
    ireq.valid = 1'b0;
    @(negedge clk);
    check("zw_data_ok_one_cycle", iresp.data_ok, 0);
    check("zw_back_idle", dut.state_q, IDLE);
    repeat (2) @(negedge clk);

    // Data store, three-cycle memory latency.
    mem_lat = 3;
    exp_req_q.push_back(mk_req(1'b1, MSIZE8, 64'h8000_1000, 8'hFF, 64'hDEAD_BEEF_0000_0001));
    exp_resp_q.push_back(mk_resp(1'b1, 64'h0000_0000_0000_0042));
    mem_q.push_back(64'h0000_0000_0000_0042);
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_1000;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    check("st_is_write", creq.is_write, 1);
    wait_dok(1'b1, 20);
    dreq.valid  = 1'b0;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    repeat (2) @(negedge clk);

    // Simultaneous requests, two-cycle latency: DATA first, INST at R+2.
    mem_lat = 2;
    exp_req_q.push_back(mk_req(1'b0, MSIZE8, 64'h8000_3008, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b1, 64'h0123_4567_89AB_CDEF));
    mem_q.push_back(64'h0123_4567_89AB_CDEF);
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_0108, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b0, 64'h7654_3210));
    mem_q.push_back(64'hFEDC_BA98_7654_3210);
    dreq.valid = 1'b1;
    dreq.addr  = 64'h8000_3008;
    dreq.size  = MSIZE8;
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0108;
    @(negedge clk);
    check("sim_owner_data", dut.owner_q, DATA);
    @(negedge clk);
    check("sim_still_data", creq.addr, 64'h8000_3008);
    wait_dok(1'b1, 20);
    dreq.valid = 1'b0;
    @(negedge clk);
    check("sim_gap_creq", creq.valid, 0);
    check("sim_gap_idle", dut.state_q, IDLE);
    @(negedge clk);
    check("sim_inst_grant", creq.valid, 1);
    check("sim_inst_addr", creq.addr, 64'h8000_0108);
    wait_dok(1'b0, 20);
    ireq.valid = 1'b0;
    repeat (2) @(negedge clk);

    // Instruction valid held one cycle past data_ok: one transaction only.
    mem_lat = 1;
    base    = txn_count;
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_0010, 8'h00, 64'h0));
    exp_resp_q.push_back(mk_resp(1'b0, 64'hCAFE_F00D));
    mem_q.push_back(64'h9999_0000_CAFE_F00D);
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0010;
    wait_dok(1'b0, 20);
    @(negedge clk);
    ireq.valid = 1'b0;
    repeat (4) @(negedge clk);
    check("held_txn_count", txn_count - base, 1);
    check("held_creq_idle", creq.valid, 0);

    // Reset while the request is on the bus.
    mem_lat = 5;
    base    = txn_count;
    exp_req_q.push_back(mk_req(1'b0, MSIZE4, 64'h8000_0020, 8'h00, 64'h0));
    ireq.valid = 1'b1;
    ireq.addr  = 64'h8000_0020;
    @(negedge clk);
    check("mid_in_req", dut.state_q, REQ);
    check("mid_creq_valid", creq.valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_creq_cleared", creq, 0);
    check("mid_state_idle", dut.state_q, IDLE);
    check("mid_owner_inst", dut.owner_q, INST);
    check("mid_iresp_zero", iresp, 0);
    check("mid_dresp_zero", dresp, 0);
    ireq.valid = 1'b0;
    reset      = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_no_beat", txn_count - base, 0);
    check("mid_creq_stays_low", creq.valid, 0);

    check("sb_req_drained", exp_req_q.size(), 0);
    check("sb_resp_drained", exp_resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
